// File: rtl/axi_arb_pkg.sv
// Shared types for the 2:1 AXI4 read arbiter: FSM encoding, AR payload bundle and source indices.
package axi_arb_pkg;

    localparam int ARB_ID_W   = 2;
    localparam int ARB_ADDR_W = 36;

    localparam logic SRC_S0 = 1'b0;
    localparam logic SRC_S1 = 1'b1;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ID_W-1:0]   id;
        logic [ARB_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; the pointer moves to the non-granted source whenever a grant is taken.
module rr_arbiter2
    import axi_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (ptr_q == SRC_S0) ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0] ? SRC_S1 : SRC_S0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= SRC_S0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Shares one AXI4 read port between two requesters: round-robin AR grant into a single registered
// AR slot, source index prepended to ARID, R beats steered back by the RID MSB with zero latency.
module axi4_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int C_ID_WIDTH        = ARB_ID_W,
    parameter int C_ADDR_WIDTH      = ARB_ADDR_W,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_MAX_OUTSTANDING = 8
) (
    input  logic                    CLK_i,
    input  logic                    nRST_i,
    input  logic [C_ID_WIDTH-1:0]   S0_ARID_i,
    input  logic [C_ADDR_WIDTH-1:0] S0_ARADDR_i,
    input  logic [7:0]              S0_ARLEN_i,
    input  logic [2:0]              S0_ARSIZE_i,
    input  logic [1:0]              S0_ARBURST_i,
    input  logic                    S0_ARVALID_i,
    output logic                    S0_ARREADY_o,
    output logic [C_ID_WIDTH-1:0]   S0_RID_o,
    output logic [C_DATA_WIDTH-1:0] S0_RDATA_o,
    output logic [1:0]              S0_RRESP_o,
    output logic                    S0_RLAST_o,
    output logic                    S0_RVALID_o,
    input  logic                    S0_RREADY_i,
    input  logic [C_ID_WIDTH-1:0]   S1_ARID_i,
    input  logic [C_ADDR_WIDTH-1:0] S1_ARADDR_i,
    input  logic [7:0]              S1_ARLEN_i,
    input  logic [2:0]              S1_ARSIZE_i,
    input  logic [1:0]              S1_ARBURST_i,
    input  logic                    S1_ARVALID_i,
    output logic                    S1_ARREADY_o,
    output logic [C_ID_WIDTH-1:0]   S1_RID_o,
    output logic [C_DATA_WIDTH-1:0] S1_RDATA_o,
    output logic [1:0]              S1_RRESP_o,
    output logic                    S1_RLAST_o,
    output logic                    S1_RVALID_o,
    input  logic                    S1_RREADY_i,
    output logic [C_ID_WIDTH:0]     M_ARID_o,
    output logic [C_ADDR_WIDTH-1:0] M_ARADDR_o,
    output logic [7:0]              M_ARLEN_o,
    output logic [2:0]              M_ARSIZE_o,
    output logic [1:0]              M_ARBURST_o,
    output logic                    M_ARVALID_o,
    input  logic                    M_ARREADY_i,
    input  logic [C_ID_WIDTH:0]     M_RID_i,
    input  logic [C_DATA_WIDTH-1:0] M_RDATA_i,
    input  logic [1:0]              M_RRESP_i,
    input  logic                    M_RLAST_i,
    input  logic                    M_RVALID_i,
    output logic                    M_RREADY_o
);

    localparam int              CW      = $clog2(C_MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(C_MAX_OUTSTANDING);
    localparam logic [0:0]      ST_IDLE  = ARB_IDLE;
    localparam logic [0:0]      ST_ISSUE = ARB_ISSUE;

    logic [1:0] s_arvalid;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic [1:0] s_hs;
    logic [1:0] r_dec;
    ar_req_t    s_req [2];
    logic       is_idle;
    logic       r_src;
    logic       m_rready;

    logic [0:0] state_q, state_d;
    ar_req_t    req_q, req_d;
    logic       src_q, src_d;

    assign s_arvalid = {S1_ARVALID_i, S0_ARVALID_i};
    assign s_req[0]  = '{id: S0_ARID_i, addr: S0_ARADDR_i, len: S0_ARLEN_i,
                         size: S0_ARSIZE_i, burst: S0_ARBURST_i};
    assign s_req[1]  = '{id: S1_ARID_i, addr: S1_ARADDR_i, len: S1_ARLEN_i,
                         size: S1_ARSIZE_i, burst: S1_ARBURST_i};

    // Ready is held low while reset is asserted even though it is otherwise combinational on VALID.
    assign is_idle = (state_q == ST_IDLE) && nRST_i;

    rr_arbiter2 u_rr (
        .clk_i  (CLK_i),
        .rst_ni (nRST_i),
        .req_i  (eligible),
        .en_i   (is_idle),
        .gnt_o  (grant)
    );

    assign r_src    = M_RID_i[C_ID_WIDTH];
    assign m_rready = r_src ? S1_RREADY_i : S0_RREADY_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [CW-1:0] cnt_q, cnt_d;

            assign eligible[gi] = s_arvalid[gi] && (cnt_q < CNT_MAX);
            assign s_hs[gi]     = is_idle && grant[gi];
            assign r_dec[gi]    = M_RVALID_i && m_rready && M_RLAST_i && (r_src == 1'(gi));

            // Decrement saturates at zero so a stray RLAST cannot wrap the limit check.
            always_comb begin
                cnt_d = cnt_q;
                if (s_hs[gi] && !r_dec[gi]) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (r_dec[gi] && !s_hs[gi] && (cnt_q != '0)) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge CLK_i or negedge nRST_i) begin
                if (!nRST_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            always @(posedge CLK_i) begin
                if (nRST_i && r_dec[gi]) begin
                    assert (cnt_q != '0)
                        else $error("axi4_read_arbiter: RLAST to source %0d with no burst in flight", gi);
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        src_d   = src_q;
        if (state_q == ST_IDLE) begin
            if (s_hs != 2'b00) begin
                state_d = ST_ISSUE;
                src_d   = s_hs[1] ? SRC_S1 : SRC_S0;
                req_d   = s_hs[1] ? s_req[1] : s_req[0];
            end
        end else if (M_ARREADY_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            src_q   <= SRC_S0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            src_q   <= src_d;
        end
    end

    assign S0_ARREADY_o = s_hs[0];
    assign S1_ARREADY_o = s_hs[1];

    assign M_ARVALID_o = (state_q == ST_ISSUE);
    assign M_ARID_o    = {src_q, req_q.id};
    assign M_ARADDR_o  = req_q.addr;
    assign M_ARLEN_o   = req_q.len;
    assign M_ARSIZE_o  = req_q.size;
    assign M_ARBURST_o = req_q.burst;

    assign S0_RID_o    = M_RID_i[C_ID_WIDTH-1:0];
    assign S0_RDATA_o  = M_RDATA_i;
    assign S0_RRESP_o  = M_RRESP_i;
    assign S0_RLAST_o  = M_RLAST_i;
    assign S0_RVALID_o = M_RVALID_i && (r_src == SRC_S0) && nRST_i;
    assign S1_RID_o    = M_RID_i[C_ID_WIDTH-1:0];
    assign S1_RDATA_o  = M_RDATA_i;
    assign S1_RRESP_o  = M_RRESP_i;
    assign S1_RLAST_o  = M_RLAST_i;
    assign S1_RVALID_o = M_RVALID_i && (r_src == SRC_S1) && nRST_i;
    assign M_RREADY_o  = m_rready;

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Randomized bench for axi4_read_arbiter: a transaction-level model predicts grants and AR payloads,
// a monitor checks the master AR port and R routing against a scoreboard queue.
module tb_axi4_read_arbiter;

    localparam int IDW  = 2;
    localparam int AW   = 36;
    localparam int DW   = 512;
    localparam int MAXO = 8;

    typedef struct {
        logic [IDW:0]  id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } ar_t;

    typedef struct {
        logic [IDW:0] id;
        int           beats;
    } burst_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // stimulus-side signals
    logic [IDW-1:0] s_arid    [2];
    logic [AW-1:0]  s_araddr  [2];
    logic [7:0]     s_arlen   [2];
    logic [2:0]     s_arsize  [2];
    logic [1:0]     s_arburst [2];
    logic           s_arvalid [2];
    logic           s_rready  [2];
    logic           m_arready;
    logic [IDW:0]   m_rid;
    logic [DW-1:0]  m_rdata;
    logic [1:0]     m_rresp;
    logic           m_rlast;
    logic           m_rvalid;

    // DUT outputs
    logic           s0_arready, s1_arready;
    logic [IDW-1:0] s0_rid, s1_rid;
    logic [DW-1:0]  s0_rdata, s1_rdata;
    logic [1:0]     s0_rresp, s1_rresp;
    logic           s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
    logic [IDW:0]   m_arid;
    logic [AW-1:0]  m_araddr;
    logic [7:0]     m_arlen;
    logic [2:0]     m_arsize;
    logic [1:0]     m_arburst;
    logic           m_arvalid, m_rready;

    axi4_read_arbiter #(
        .C_ID_WIDTH(IDW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(MAXO)
    ) dut (
        .CLK_i(clk), .nRST_i(rst_n),
        .S0_ARID_i(s_arid[0]), .S0_ARADDR_i(s_araddr[0]), .S0_ARLEN_i(s_arlen[0]),
        .S0_ARSIZE_i(s_arsize[0]), .S0_ARBURST_i(s_arburst[0]), .S0_ARVALID_i(s_arvalid[0]),
        .S0_ARREADY_o(s0_arready), .S0_RID_o(s0_rid), .S0_RDATA_o(s0_rdata), .S0_RRESP_o(s0_rresp),
        .S0_RLAST_o(s0_rlast), .S0_RVALID_o(s0_rvalid), .S0_RREADY_i(s_rready[0]),
        .S1_ARID_i(s_arid[1]), .S1_ARADDR_i(s_araddr[1]), .S1_ARLEN_i(s_arlen[1]),
        .S1_ARSIZE_i(s_arsize[1]), .S1_ARBURST_i(s_arburst[1]), .S1_ARVALID_i(s_arvalid[1]),
        .S1_ARREADY_o(s1_arready), .S1_RID_o(s1_rid), .S1_RDATA_o(s1_rdata), .S1_RRESP_o(s1_rresp),
        .S1_RLAST_o(s1_rlast), .S1_RVALID_o(s1_rvalid), .S1_RREADY_i(s_rready[1]),
        .M_ARID_o(m_arid), .M_ARADDR_o(m_araddr), .M_ARLEN_o(m_arlen), .M_ARSIZE_o(m_arsize),
        .M_ARBURST_o(m_arburst), .M_ARVALID_o(m_arvalid), .M_ARREADY_i(m_arready),
        .M_RID_i(m_rid), .M_RDATA_i(m_rdata), .M_RRESP_i(m_rresp), .M_RLAST_i(m_rlast),
        .M_RVALID_i(m_rvalid), .M_RREADY_o(m_rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int     cnt_m [2];
    bit     ptr_m;
    bit     slot_m;
    ar_t    ar_exp_q [$];
    burst_t bursts [$];
    bit     r_active;
    int     r_idx;
    int     p_arv [2];
    int     p_mready, p_rvalid, p_rready;
    int     n_ar_seen = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic new_request(input int n);
        s_arvalid[n] = ($urandom_range(99) < p_arv[n]);
        s_arid[n]    = IDW'($urandom);
        s_araddr[n]  = {4'($urandom), 32'($urandom)};
        s_arlen[n]   = 8'($urandom_range(3));
        s_arsize[n]  = 3'($urandom);
        s_arburst[n] = 2'($urandom);
    endtask

    task automatic drive(input bit [1:0] ar_done, input bit r_hs);
        burst_t b;
        for (int n = 0; n < 2; n++) begin
            if (ar_done[n] || !s_arvalid[n]) new_request(n);
            s_rready[n] = ($urandom_range(99) < p_rready);
        end
        m_arready = ($urandom_range(99) < p_mready);
        if (r_hs) begin
            b = bursts[r_idx];
            b.beats = b.beats - 1;
            if (b.beats == 0) bursts.delete(r_idx);
            else bursts[r_idx] = b;
            r_active = 1'b0;
        end
        // any outstanding burst may supply the next beat, so IDs interleave freely
        if (!r_active && bursts.size() > 0 && $urandom_range(99) < p_rvalid) begin
            r_idx = $urandom_range(bursts.size() - 1);
            m_rid = bursts[r_idx].id;
            for (int k = 0; k < DW / 32; k++) m_rdata[k*32 +: 32] = $urandom;
            m_rresp  = 2'($urandom);
            m_rlast  = (bursts[r_idx].beats == 1);
            r_active = 1'b1;
        end
        m_rvalid = r_active;
        if (!r_active) m_rlast = 1'b0;
    endtask

    // one clock: predict and check at the falling edge, then drive just after the rising edge
    task automatic step();
        bit [1:0] elig, exp_gnt, ar_done;
        bit       src, r_hs, rsel;
        ar_t      e;
        @(negedge clk);
        for (int n = 0; n < 2; n++) elig[n] = s_arvalid[n] && (cnt_m[n] < MAXO);
        exp_gnt = 2'b00;
        if (!slot_m) exp_gnt = (elig == 2'b11) ? (ptr_m ? 2'b10 : 2'b01) : elig;
        chk("s0_arready", 512'(s0_arready), 512'(exp_gnt[0]));
        chk("s1_arready", 512'(s1_arready), 512'(exp_gnt[1]));
        chk("m_arvalid", 512'(m_arvalid), 512'(slot_m));
        if (slot_m && m_arready) slot_m = 1'b0;
        if (exp_gnt != 2'b00) begin
            src     = exp_gnt[1];
            ptr_m   = !src;
            e.id    = {src, s_arid[src]};
            e.addr  = s_araddr[src];
            e.len   = s_arlen[src];
            e.size  = s_arsize[src];
            e.burst = s_arburst[src];
            ar_exp_q.push_back(e);
            slot_m = 1'b1;
            cnt_m[src]++;
        end
        rsel = m_rid[IDW];
        r_hs = r_active && s_rready[rsel];
        if (r_hs && m_rlast) cnt_m[rsel]--;
        ar_done[0] = s_arvalid[0] && s0_arready;
        ar_done[1] = s_arvalid[1] && s1_arready;
        @(posedge clk);
        #1;
        drive(ar_done, r_hs);
    endtask

    task automatic clear_model();
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        ptr_m    = 1'b0;
        slot_m   = 1'b0;
        ar_exp_q.delete();
        bursts.delete();
        r_active = 1'b0;
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_arvalid"}, 512'(m_arvalid), 512'(0));
        chk({tag, "_m_arid"},    512'(m_arid),    512'(0));
        chk({tag, "_m_araddr"},  512'(m_araddr),  512'(0));
        chk({tag, "_m_arlen"},   512'(m_arlen),   512'(0));
        chk({tag, "_s0_arready"}, 512'(s0_arready), 512'(0));
        chk({tag, "_s1_arready"}, 512'(s1_arready), 512'(0));
        chk({tag, "_s0_rvalid"}, 512'(s0_rvalid), 512'(0));
        chk({tag, "_s1_rvalid"}, 512'(s1_rvalid), 512'(0));
    endtask

    task automatic run_phase(input int cycles, input int pa0, input int pa1, input int pm,
                             input int prv, input int prr);
        p_arv[0] = pa0; p_arv[1] = pa1;
        p_mready = pm; p_rvalid = prv; p_rready = prr;
        for (int i = 0; i < cycles; i++) step();
    endtask

    // monitor: compares whatever the DUT presents against the scoreboard
    always @(negedge clk) begin
        ar_t e;
        #1;
        if (rst_n) begin
            if (m_arvalid) begin
                n_checks++;
                if (ar_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ar_unexpected: got M_ARVALID=1 with id %0h expected no request", m_arid);
                end else begin
                    e = ar_exp_q[0];
                    chk("m_arid",    512'(m_arid),    512'(e.id));
                    chk("m_araddr",  512'(m_araddr),  512'(e.addr));
                    chk("m_arlen",   512'(m_arlen),   512'(e.len));
                    chk("m_arsize",  512'(m_arsize),  512'(e.size));
                    chk("m_arburst", 512'(m_arburst), 512'(e.burst));
                    if (m_arready) begin
                        void'(ar_exp_q.pop_front());
                        bursts.push_back('{id: e.id, beats: int'(e.len) + 1});
                        n_ar_seen++;
                        $display("AR  #%0d src=S%0d id=%0d addr=%h len=%0d t=%0t",
                                 n_ar_seen, e.id[IDW], e.id[IDW-1:0], e.addr, e.len, $time);
                    end
                end
            end
            chk("s0_rvalid", 512'(s0_rvalid), 512'(m_rvalid && !m_rid[IDW]));
            chk("s1_rvalid", 512'(s1_rvalid), 512'(m_rvalid && m_rid[IDW]));
            chk("m_rready",  512'(m_rready),  512'(m_rid[IDW] ? s_rready[1] : s_rready[0]));
            if (m_rvalid) begin
                chk("r_data", m_rid[IDW] ? s1_rdata : s0_rdata, m_rdata);
                chk("r_id",   512'(m_rid[IDW] ? s1_rid : s0_rid), 512'(m_rid[IDW-1:0]));
                chk("r_resp", 512'(m_rid[IDW] ? s1_rresp : s0_rresp), 512'(m_rresp));
                chk("r_last", 512'(m_rid[IDW] ? s1_rlast : s0_rlast), 512'(m_rlast));
            end
        end
    end

    initial begin
        p_arv[0] = 0; p_arv[1] = 0;
        p_mready = 0; p_rvalid = 0; p_rready = 0;
        for (int n = 0; n < 2; n++) begin
            s_arid[n] = '0; s_araddr[n] = '0; s_arlen[n] = '0;
            s_arsize[n] = '0; s_arburst[n] = '0; s_rready[n] = 1'b1;
        end
        // requests and an R beat pending during reset must not leak through
        s_arvalid[0] = 1'b1;
        s_arvalid[1] = 1'b1;
        m_arready = 1'b1;
        m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b1; m_rvalid = 1'b1;
        clear_model();
        m_rvalid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("por");
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_arvalid[0] = 1'b0;
        s_arvalid[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // S1 alone, no R return: it fills to the limit, then S0 must still be served
        run_phase(40, 0, 90, 80, 0, 100);
        run_phase(30, 90, 90, 80, 0, 100);
        // returns start: interleaved beats, backpressure on both sources
        run_phase(600, 60, 60, 70, 60, 60);
        // long AR stalls on the master side
        run_phase(300, 80, 80, 15, 50, 80);

        // asynchronous reset mid-operation, off the clock edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        clear_model();
        s_arvalid[0] = 1'b0;
        s_arvalid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // both request together after reset: the pointer has returned to S0
        p_arv[0] = 100; p_arv[1] = 100;
        new_request(0);
        new_request(1);
        m_arready = 1'b1;
        run_phase(500, 50, 50, 60, 60, 70);
        run_phase(400, 90, 90, 90, 90, 90);

        // drain all outstanding work
        p_arv[0] = 0; p_arv[1] = 0;
        p_mready = 100; p_rvalid = 100; p_rready = 100;
        for (int i = 0; i < 3000 && (bursts.size() > 0 || slot_m || r_active || s_arvalid[0] || s_arvalid[1]); i++)
            step();
        n_checks++;
        if (bursts.size() > 0 || slot_m || r_active) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d bursts still open expected 0", bursts.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
